// File: rtl/pim_pkg.sv
// pim_pkg: default geometry of the PIM macro and the width of the full-precision MAC sum.
package pim_pkg;
    localparam int PIM_DWIDTH = 32;
    localparam int PIM_AWIDTH = 8;
    localparam int PIM_PWIDTH = 32;
    localparam int PIM_PDEPTH = 256;
    function automatic int acc_width(input int pwidth, input int pdepth);
        return pwidth + $clog2(pdepth);
    endfunction
endpackage

// File: rtl/pim_mac_tree.sv
// pim_mac_tree: combinational binary adder tree summing every row whose rwl bit is set.
module pim_mac_tree
    import pim_pkg::*;
#(
    parameter int PWIDTH = PIM_PWIDTH,
    parameter int PDEPTH = PIM_PDEPTH,
    parameter int SWIDTH = acc_width(PWIDTH, PDEPTH)
) (
    input  logic [PDEPTH*PWIDTH-1:0] i_rows,
    input  logic [PDEPTH-1:0]        i_rwl,
    output logic [SWIDTH-1:0]        o_sum
);
    localparam int LV = PDEPTH > 1 ? $clog2(PDEPTH) : 0;
    localparam int N  = 1 << LV;
    logic [N*PWIDTH-1:0] w_rows;
    logic [N-1:0]        w_rwl;
    logic [SWIDTH-1:0]   w_node [0:2*N-2];
    assign w_rows = (N*PWIDTH)'(i_rows);
    assign w_rwl  = N'(i_rwl);
    // Heap layout: leaves at N-1.., node k sums children 2k+1 and 2k+2.
    always_comb begin
        for (int i = 0; i < N; i++)
            w_node[N-1+i] = w_rwl[i] ? SWIDTH'(w_rows[i*PWIDTH +: PWIDTH]) : '0;
        for (int k = N - 2; k >= 0; k--)
            w_node[k] = w_node[2*k+1] + w_node[2*k+2];
    end
    assign o_sum = w_node[0];
endmodule

// File: rtl/pim_model.sv
// pim_model: behavioural PIM macro - row array with single-port write/read and an
// in-array multiply-accumulate over the rows selected by rwl.
module pim_model
    import pim_pkg::*;
#(
    parameter int PIM_ADDR_BEGIN = 0,
    parameter int DWIDTH         = PIM_DWIDTH,
    parameter int AWIDTH         = PIM_AWIDTH,
    parameter int PWIDTH         = PIM_PWIDTH,
    parameter int PDEPTH         = PIM_PDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] d,
    input  logic              w_en,
    input  logic              p_en,
    input  logic [PDEPTH-1:0] rwl,
    output logic [PWIDTH-1:0] q,
    output logic [DWIDTH-1:0] mac_out
);
    localparam int SW = acc_width(PWIDTH, PDEPTH);
    localparam int IW = PDEPTH > 1 ? $clog2(PDEPTH) : 1;
    logic [PWIDTH-1:0]        r_mem [0:PDEPTH-1];
    logic [PWIDTH-1:0]        r_q;
    logic [DWIDTH-1:0]        r_mac;
    logic [31:0]              w_addr;
    logic                     w_in_range;
    logic [IW-1:0]            w_idx;
    logic [PDEPTH*PWIDTH-1:0] w_rows;
    logic [SW-1:0]            w_sum;
    assign w_addr     = 32'(addr);
    assign w_in_range = w_addr >= 32'(PIM_ADDR_BEGIN) && w_addr < 32'(PIM_ADDR_BEGIN + PDEPTH);
    assign w_idx      = IW'(w_addr - 32'(PIM_ADDR_BEGIN));
    for (genvar i = 0; i < PDEPTH; i++) begin : g_rows
        assign w_rows[i*PWIDTH +: PWIDTH] = r_mem[i];
    end
    pim_mac_tree #(.PWIDTH(PWIDTH), .PDEPTH(PDEPTH), .SWIDTH(SW)) u_tree (
        .i_rows(w_rows),
        .i_rwl (rwl),
        .o_sum (w_sum)
    );
    // A write cycle freezes q and mac_out; only non-write cycles read and accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PDEPTH; i++) r_mem[i] <= '0;
            r_q   <= '0;
            r_mac <= '0;
        end else if (w_en) begin
            if (w_in_range) r_mem[w_idx] <= PWIDTH'(d);
        end else begin
            r_q <= w_in_range ? r_mem[w_idx] : '0;
            if (p_en) r_mac <= DWIDTH'(w_sum);
        end
    end
    assign q       = r_q;
    assign mac_out = r_mac;
endmodule

// File: tb/tb_pim_model.sv
// tb_pim_model: directed and random checks of two pim_model instances (base 0 and base 0x10)
// against an array-based reference model.
module tb_pim_model;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   addr = '0;
    logic [31:0]  d = '0;
    logic         w_en = 1'b0;
    logic         p_en = 1'b0;
    logic [255:0] rwl = '0;
    logic [31:0]  q0, q1, mac0, mac1;

    pim_model #(.PIM_ADDR_BEGIN(0)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .d(d), .w_en(w_en), .p_en(p_en),
        .rwl(rwl), .q(q0), .mac_out(mac0)
    );
    pim_model #(.PIM_ADDR_BEGIN(16)) u_dut_ofs (
        .clk(clk), .rst(rst), .addr(addr), .d(d), .w_en(w_en), .p_en(p_en),
        .rwl(rwl), .q(q1), .mac_out(mac1)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m [2][256];
    logic [31:0] eq [2];
    logic [31:0] emac [2];
    int          base [2] = '{0, 16};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) m[k][i] = '0;
            eq[k]   = '0;
            emac[k] = '0;
        end
    endfunction

    function automatic logic [31:0] msum(input int k, input logic [255:0] rw);
        longint unsigned s = 0;
        for (int i = 0; i < 256; i++) if (rw[i]) s += 64'(m[k][i]);
        return s[31:0];
    endfunction

    task automatic cyc(input string tag, input bit we, input bit pe, input logic [7:0] a,
                       input logic [31:0] dd, input logic [255:0] rw);
        int idx [2];
        bit inr [2];
        w_en = we; p_en = pe; addr = a; d = dd; rwl = rw;
        for (int k = 0; k < 2; k++) begin
            idx[k] = int'(a) - base[k];
            inr[k] = idx[k] >= 0 && idx[k] < 256;
            if (!we) begin
                eq[k] = inr[k] ? m[k][idx[k]] : '0;
                if (pe) emac[k] = msum(k, rw);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (we && inr[k]) m[k][idx[k]] = dd;
        check({tag, ".q0"}, q0, eq[0]);
        check({tag, ".mac0"}, mac0, emac[0]);
        check({tag, ".q1"}, q1, eq[1]);
        check({tag, ".mac1"}, mac1, emac[1]);
    endtask

    initial begin
        logic [255:0] rw;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.q", q0, 32'h0);
        check("rst.mac", mac0, 32'h0);

        cyc("wr5", 1, 0, 8'd5, 32'hDEADBEEF, '0);
        cyc("rd5", 0, 0, 8'd5, 32'h0, '0);
        check("rd5.const", q0, 32'hDEADBEEF);
        cyc("rd6", 0, 0, 8'd6, 32'h0, '0);
        check("rd6.const", q0, 32'h0);

        for (int i = 0; i < 4; i++) cyc("wrow", 1, 0, 8'(i), 32'(i + 1), '0);
        cyc("mac1011", 0, 1, 8'd0, 32'h0, 256'b1011);
        check("mac1011.const", mac0, 32'd7);
        cyc("mac0", 0, 1, 8'd0, 32'h0, '0);
        check("mac0.const", mac0, 32'd0);
        cyc("hold", 0, 0, 8'd0, 32'h0, 256'hF);
        check("hold.const", mac0, 32'd0);

        cyc("ovf0", 1, 0, 8'd0, 32'hFFFFFFFF, '0);
        cyc("ovf1", 1, 0, 8'd1, 32'hFFFFFFFF, '0);
        cyc("ovf", 0, 1, 8'd0, 32'h0, 256'b11);
        check("ovf.const", mac0, 32'hFFFFFFFE);

        cyc("prio", 1, 1, 8'd0, 32'd9, 256'b1);
        check("prio.const", mac0, 32'hFFFFFFFE);
        cyc("prio.mac", 0, 1, 8'd0, 32'h0, 256'b1);
        check("prio.mac.const", mac0, 32'd9);

        cyc("rng.wr10", 1, 0, 8'h10, 32'h0000A5A5, '0);
        cyc("rng.wr05", 1, 0, 8'h05, 32'd7, '0);
        cyc("rng.rd10", 0, 0, 8'h10, 32'h0, '0);
        check("rng.rd10.const", q1, 32'h0000A5A5);
        cyc("rng.rd05", 0, 0, 8'h05, 32'h0, '0);
        check("rng.rd05.const", q1, 32'h0);

        cyc("mid.wr", 1, 0, 8'd5, 32'h1234, '0);
        cyc("mid.rd", 0, 1, 8'd5, 32'h0, 256'h20);
        check("mid.rd.const", q0, 32'h1234);
        w_en = 1'b1; addr = 8'd7; d = 32'h55;
        #2 rst = 1'b1;
        #1;
        check("arst.q", q0, 32'h0);
        check("arst.mac", mac0, 32'h0);
        model_reset();
        w_en = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 256; i++) cyc("clr", 0, 0, 8'(i), 32'h0, '0);

        for (int n = 0; n < 1500; n++) begin
            for (int j = 0; j < 8; j++) rw[j*32 +: 32] = $urandom;
            if ($urandom_range(0, 3) == 0) rw = rw & 256'hFFFF_FFFF_FFFF;
            cyc("rnd", $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40)),
                ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom), rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
